// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared definitions for the pipeline hold controller: hold encodings,
// controller state type and the zero word used for idle redirect targets.
package pipe_hold_ctrl_pkg;

    typedef logic [2:0] hold_flag_t;

    localparam hold_flag_t HOLD_NONE = 3'd0;
    localparam hold_flag_t HOLD_PC   = 3'd1;
    localparam hold_flag_t HOLD_ID   = 3'd3;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_BUSWAIT = 2'd2
    } ctrl_state_e;

endpackage : pipe_hold_ctrl_pkg

// File: rtl/pipe_hold_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear. The count sticks at all-ones
// instead of wrapping. Clear has priority over enable. WIDTH must be >= 2.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_r;

    // Count register: clear, saturating increment, or hold.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_r <= {WIDTH{1'b0}};
        end else if (en && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule : sat_counter

// File: rtl/pipe_hold_ctrl.sv
// Central pipeline hold/redirect controller. Folds ex/clint/rib hold requests
// into one hold flag, picks the redirect target, stretches flushes over
// FLUSH_CYCLES, times out runaway bus stalls and counts stall cycles.
module pipe_hold_ctrl
    import pipe_hold_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int RIB_TIMEOUT  = 255,
    parameter int TO_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_ex_i,
    input  logic [31:0] jump_addr_ex_i,
    input  logic        hold_req_ex_i,
    input  logic        hold_req_clint_i,
    input  logic        int_assert_i,
    input  logic [31:0] int_addr_i,
    input  logic        hold_req_rib_i,
    input  logic        timeout_clr_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        bus_timeout_o,
    output logic [31:0] stall_cnt_o
);

    // The redirect cycle itself is the first Hold_Id cycle, so the FLUSH state
    // only has to cover FLUSH_CYCLES-1 further cycles (counter FLUSH_CYCLES-2 .. 0).
    localparam bit              FLUSH_MULTI  = (FLUSH_CYCLES > 1);
    localparam logic [3:0]      FLUSH_RELOAD = FLUSH_MULTI ? 4'(FLUSH_CYCLES - 2) : 4'd0;
    localparam logic [TO_W-1:0] RIB_LIMIT    = TO_W'(RIB_TIMEOUT);

    ctrl_state_e     state_r, state_nxt_s, eff_state_s;
    logic [3:0]      flush_cnt_r, flush_cnt_nxt_s;
    logic            rib_mask_r, rib_mask_nxt_s;
    logic            bus_timeout_r, bus_timeout_nxt_s;
    logic            redirect_s, rib_act_s, to_hit_s;
    logic            rib_en_s, rib_clr_s;
    logic [TO_W-1:0] rib_cnt_s;
    logic [31:0]     jump_addr_s;
    hold_flag_t      hold_flag_s;

    // Redirect request and target select; an interrupt beats an ex branch.
    always_comb begin
        redirect_s = int_assert_i | jump_flag_ex_i;
        if (int_assert_i) begin
            jump_addr_s = int_addr_i;
        end else if (jump_flag_ex_i) begin
            jump_addr_s = jump_addr_ex_i;
        end else begin
            jump_addr_s = ZERO_WORD;
        end
    end

    // Effective state: while rst is sampled high the hold flag already looks
    // like RUN. The stall that reaches RIB_LIMIT counted cycles is the timeout
    // cycle and no longer holds the pc, capping Hold_Pc at RIB_TIMEOUT cycles.
    always_comb begin
        if (rst) begin
            eff_state_s = ST_RUN;
        end else begin
            eff_state_s = state_r;
        end
        to_hit_s  = (eff_state_s == ST_BUSWAIT) && hold_req_rib_i && (rib_cnt_s == RIB_LIMIT);
        rib_act_s = hold_req_rib_i && !rib_mask_r && !to_hit_s;
    end

    // Hold flag priority: flush/redirect, then ex/clint, then bus stall.
    always_comb begin
        if (redirect_s || (eff_state_s == ST_FLUSH)) begin
            hold_flag_s = HOLD_ID;
        end else if (hold_req_ex_i || hold_req_clint_i) begin
            hold_flag_s = HOLD_ID;
        end else if (rib_act_s) begin
            hold_flag_s = HOLD_PC;
        end else begin
            hold_flag_s = HOLD_NONE;
        end
    end

    // Next-state, flush counter, rib mask and sticky timeout logic.
    always_comb begin
        state_nxt_s       = state_r;
        flush_cnt_nxt_s   = flush_cnt_r;
        rib_mask_nxt_s    = rib_mask_r;
        bus_timeout_nxt_s = bus_timeout_r;
        case (state_r)
            ST_RUN: begin
                if (redirect_s && FLUSH_MULTI) begin
                    state_nxt_s     = ST_FLUSH;
                    flush_cnt_nxt_s = FLUSH_RELOAD;
                end else if (rib_act_s) begin
                    state_nxt_s = ST_BUSWAIT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (redirect_s) begin
                    flush_cnt_nxt_s = FLUSH_RELOAD;
                end else if (flush_cnt_r == 4'd0) begin
                    if (rib_act_s) begin
                        state_nxt_s = ST_BUSWAIT;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else begin
                    flush_cnt_nxt_s = flush_cnt_r - 4'd1;
                end
            end
            ST_BUSWAIT: begin
                if (redirect_s) begin
                    if (FLUSH_MULTI) begin
                        state_nxt_s     = ST_FLUSH;
                        flush_cnt_nxt_s = FLUSH_RELOAD;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else if (!hold_req_rib_i) begin
                    state_nxt_s = ST_RUN;
                end else if (to_hit_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_BUSWAIT;
                end
            end
            default: begin
                state_nxt_s     = ST_RUN;
                flush_cnt_nxt_s = 4'd0;
            end
        endcase

        if (to_hit_s) begin
            rib_mask_nxt_s = 1'b1;
        end else if (!hold_req_rib_i) begin
            rib_mask_nxt_s = 1'b0;
        end else begin
            rib_mask_nxt_s = rib_mask_r;
        end

        if (to_hit_s) begin
            bus_timeout_nxt_s = 1'b1;
        end else if (timeout_clr_i) begin
            bus_timeout_nxt_s = 1'b0;
        end else begin
            bus_timeout_nxt_s = bus_timeout_r;
        end

        // rib_cnt counts BUSWAIT cycles: it is 0 outside BUSWAIT, so entering
        // BUSWAIT from any state increments it to 1.
        rib_en_s  = (state_nxt_s == ST_BUSWAIT);
        rib_clr_s = (state_nxt_s != ST_BUSWAIT);
    end

    // Controller state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= ST_RUN;
            flush_cnt_r   <= 4'd0;
            rib_mask_r    <= 1'b0;
            bus_timeout_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            flush_cnt_r   <= flush_cnt_nxt_s;
            rib_mask_r    <= rib_mask_nxt_s;
            bus_timeout_r <= bus_timeout_nxt_s;
        end
    end

    sat_counter #(.WIDTH(TO_W)) u_rib_cnt (
        .clk (clk),
        .clr (rst | rib_clr_s),
        .en  (rib_en_s),
        .cnt (rib_cnt_s)
    );

    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk (clk),
        .clr (rst),
        .en  (hold_flag_s != HOLD_NONE),
        .cnt (stall_cnt_o)
    );

    assign hold_flag_o   = hold_flag_s;
    assign jump_flag_o   = redirect_s;
    assign jump_addr_o   = jump_addr_s;
    assign bus_timeout_o = bus_timeout_r;

endmodule : pipe_hold_ctrl
